// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the snooping-bus arbiter: sizes, bus op codes,
// processor ids, FSM states and small decode helpers.
package bus_arbiter_pkg;

  localparam int unsigned NReq = 3;
  localparam int unsigned TagW = 3;
  localparam int unsigned OpW  = 2;
  localparam int unsigned IdW  = 2;

  localparam logic [OpW-1:0] OpIllegal = 2'b00;
  localparam logic [OpW-1:0] OpRdMiss  = 2'b01;
  localparam logic [OpW-1:0] OpWrMiss  = 2'b10;
  localparam logic [OpW-1:0] OpInv     = 2'b11;

  localparam logic [IdW-1:0] IdP1 = 2'd0;
  localparam logic [IdW-1:0] IdP2 = 2'd1;
  localparam logic [IdW-1:0] IdP3 = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StWrbk,
    StMemrd,
    StDone
  } state_e;

  function automatic logic [NReq-1:0] id_to_onehot(logic [IdW-1:0] id);
    case (id)
      IdP1:    return 3'b001;
      IdP2:    return 3'b010;
      IdP3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Caller guarantees at least one bit set.
  function automatic logic [IdW-1:0] lowest_id(logic [NReq-1:0] v);
    if (v[0]) return IdP1;
    else if (v[1]) return IdP2;
    else return IdP3;
  endfunction

  function automatic logic [IdW-1:0] next_id(logic [IdW-1:0] id);
    return (id == IdP3) ? IdP1 : id + 2'd1;
  endfunction

  // An illegal op carries no memory traffic, same as an invalidate.
  function automatic logic [OpW-1:0] norm_op(logic [OpW-1:0] op);
    return (op == OpIllegal) ? OpInv : op;
  endfunction

  function automatic logic [OpW-1:0] sel_op(logic [NReq*OpW-1:0] ops, logic [IdW-1:0] id);
    case (id)
      IdP2:    return ops[3:2];
      IdP3:    return ops[5:4];
      default: return ops[1:0];
    endcase
  endfunction

  function automatic logic [TagW-1:0] sel_tag(logic [NReq*TagW-1:0] tags, logic [IdW-1:0] id);
    case (id)
      IdP2:    return tags[5:3];
      IdP3:    return tags[8:6];
      default: return tags[2:0];
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Processor-side request/grant and bus/memory sequencing signals of the arbiter.
// slave: the arbiter's view; master: the processors/bus/memory side.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [NReq-1:0]      req;
  logic [NReq*OpW-1:0]  req_op;
  logic [NReq*TagW-1:0] req_tag;
  logic [NReq-1:0]      snoop_dirty;
  logic [NReq-1:0]      gnt;
  logic [IdW-1:0]       gnt_id;
  logic                 bus_valid;
  logic [OpW-1:0]       bus_op;
  logic [TagW-1:0]      bus_tag;
  logic [IdW-1:0]       wb_sel;
  logic                 mem_wr;
  logic                 mem_rd;
  logic [NReq-1:0]      ack;
  logic                 busy;

  modport slave (
    input  req, req_op, req_tag, snoop_dirty,
    output gnt, gnt_id, bus_valid, bus_op, bus_tag, wb_sel, mem_wr, mem_rd, ack, busy
  );

  modport master (
    output req, req_op, req_tag, snoop_dirty,
    input  gnt, gnt_id, bus_valid, bus_op, bus_tag, wb_sel, mem_wr, mem_rd, ack, busy
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner selection among the requesters.
// Default: round robin starting at ptr. With ARB_FIXED_PRIO_EN defined the
// pointer input disappears and P1 > P2 > P3 fixed priority is used instead.
module bus_arbiter_rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [NReq-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IdW-1:0]  ptr,
`endif
  output logic [NReq-1:0] win,
  output logic [IdW-1:0]  win_id,
  output logic            any
);

`ifndef ARB_FIXED_PRIO_EN
  logic [2*NReq-1:0] dbl;
  logic [NReq-1:0]   rot;
  logic [IdW-1:0]    off;
  logic [IdW:0]      sum;

  // Rotate requests so bit 0 is the pointer position, take the first set
  // bit, then map the offset back to an absolute id.
  always_comb begin
    dbl    = {req, req};
    rot    = dbl[ptr +: NReq];
    off    = 2'd0;
    if (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else off = 2'd2;
    sum    = {1'b0, ptr} + {1'b0, off};
    win_id = (sum >= 3'd3) ? IdW'(sum - 3'd3) : sum[IdW-1:0];
    any    = |req;
    win    = any ? id_to_onehot(win_id) : '0;
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    any    = |req;
    win_id = any ? lowest_id(req) : IdP1;
    win    = any ? id_to_onehot(win_id) : '0;
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: grants one processor per transaction, broadcasts its
// message for one snoop cycle, then sequences owner writeback and memory read
// before acking the requester. All outputs come from registered state.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed priority instead of round robin).
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  logic [NReq-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic [OpW-1:0]  op_q, op_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic [IdW-1:0]  wb_sel_q, wb_sel_d;
  logic [NReq-1:0] win;
  logic [NReq-1:0] dirty;
  logic [IdW-1:0]  win_id;
  logic            any_req;
`ifndef ARB_FIXED_PRIO_EN
  logic [IdW-1:0]  ptr_q, ptr_d;
`endif

  bus_arbiter_rr_picker u_picker (
    .req    (bus.req),
`ifndef ARB_FIXED_PRIO_EN
    .ptr    (ptr_q),
`endif
    .win    (win),
    .win_id (win_id),
    .any    (any_req)
  );

  // Next-state: grant latch in IDLE, path choice in SNOOP, pointer advance in DONE.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    op_d     = op_q;
    tag_d    = tag_q;
    wb_sel_d = wb_sel_q;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    // The requester never writes back to itself.
    dirty    = bus.snoop_dirty & ~gnt_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d    = win;
          gnt_id_d = win_id;
          op_d     = norm_op(sel_op(bus.req_op, win_id));
          tag_d    = sel_tag(bus.req_tag, win_id);
          state_d  = StSnoop;
        end
      end
      StSnoop: begin
        if (|dirty) begin
          wb_sel_d = lowest_id(dirty);
          state_d  = StWrbk;
        end else if (op_q != OpInv) begin
          state_d = StMemrd;
        end else begin
          state_d = StDone;
        end
      end
      StWrbk: begin
        state_d = (op_q != OpInv) ? StMemrd : StDone;
      end
      StMemrd: begin
        state_d = StDone;
      end
      StDone: begin
        gnt_d   = '0;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = next_id(gnt_id_q);
`endif
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= IdP1;
      op_q     <= '0;
      tag_q    <= '0;
      wb_sel_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q    <= IdP1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      wb_sel_q <= wb_sel_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Outputs decoded from state; bus_tag stays up through MEMRD as the memory address.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.gnt       = gnt_q;
    bus.gnt_id    = bus.busy ? gnt_id_q : '0;
    bus.bus_valid = (state_q == StSnoop);
    bus.bus_op    = bus.busy ? op_q : '0;
    bus.bus_tag   = bus.busy ? tag_q : '0;
    bus.wb_sel    = (state_q == StWrbk) ? wb_sel_q : '0;
    bus.mem_wr    = (state_q == StWrbk);
    bus.mem_rd    = (state_q == StMemrd);
    bus.ack       = (state_q == StDone) ? gnt_q : '0;
  end

endmodule
